// File: rtl/mfp_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// mfp_ahb_master_arbiter : two-master AHB-Lite arbiter (MIPS core / SREC loader)
// Rev 1.0
// ============================================================================
module mfp_ahb_master_arbiter #(
  parameter int LDR_RUN_MAX = 0,
  parameter int CNT_W       = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,

  input  logic [31:0]      cpu_HADDR,
  input  logic [31:0]      cpu_HWDATA,
  input  logic [2:0]       cpu_HBURST,
  input  logic             cpu_HMASTLOCK,
  input  logic [3:0]       cpu_HPROT,
  input  logic [2:0]       cpu_HSIZE,
  input  logic [1:0]       cpu_HTRANS,
  input  logic             cpu_HWRITE,
  output logic             cpu_HREADY,
  output logic             cpu_HRESP,
  output logic [31:0]      cpu_HRDATA,

  input  logic [31:0]      ldr_HADDR,
  input  logic [31:0]      ldr_HWDATA,
  input  logic [2:0]       ldr_HBURST,
  input  logic             ldr_HMASTLOCK,
  input  logic [3:0]       ldr_HPROT,
  input  logic [2:0]       ldr_HSIZE,
  input  logic [1:0]       ldr_HTRANS,
  input  logic             ldr_HWRITE,
  input  logic             ldr_active,

  output logic [31:0]      s_HADDR,
  output logic [31:0]      s_HWDATA,
  output logic [2:0]       s_HBURST,
  output logic             s_HMASTLOCK,
  output logic [3:0]       s_HPROT,
  output logic [2:0]       s_HSIZE,
  output logic [1:0]       s_HTRANS,
  output logic             s_HWRITE,
  input  logic             s_HREADY,
  input  logic             s_HRESP,
  input  logic [31:0]      s_HRDATA,

  output logic             grant_ldr,
  output logic [CNT_W-1:0] ldr_xfer_count
);

  localparam int              RUN_W       = (LDR_RUN_MAX > 0) ? $clog2(LDR_RUN_MAX + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX_C  = RUN_W'(LDR_RUN_MAX);
  localparam logic [1:0]      HTRANS_IDLE = 2'b00;

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    LDR_OWN = 1'b1
  } arb_state_t;

  arb_state_t       state_q, state_d;
  logic             dp_owner_q, dp_owner_d;      // data-phase owner, 1 = LDR
  logic             dp_valid_q, dp_valid_d;
  logic             slot_pending_q, slot_pending_d;
  logic             ldr_active_q, ldr_active_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic grant_is_ldr;
  logic own_idle;
  logic own_lock;
  logic handover_ok;
  logic ldr_accept;
  logic cpu_accept;
  logic ldr_rise;
  logic force_cpu;

  assign grant_is_ldr = (state_q == LDR_OWN);
  assign own_idle     = grant_is_ldr ? (ldr_HTRANS == HTRANS_IDLE) : (cpu_HTRANS == HTRANS_IDLE);
  assign own_lock     = grant_is_ldr ? ldr_HMASTLOCK : cpu_HMASTLOCK;
  assign handover_ok  = s_HREADY && own_idle && !own_lock;
  assign ldr_accept   = grant_is_ldr && ldr_HTRANS[1] && s_HREADY;
  assign cpu_accept   = !grant_is_ldr && cpu_HTRANS[1] && s_HREADY;
  assign ldr_rise     = ldr_active && !ldr_active_q;
  assign force_cpu    = (LDR_RUN_MAX != 0) && (run_cnt_q == RUN_MAX_C) && cpu_HTRANS[1];

  // Address phase follows the grant; write data follows the data-phase owner.
  assign s_HADDR     = grant_is_ldr ? ldr_HADDR     : cpu_HADDR;
  assign s_HBURST    = grant_is_ldr ? ldr_HBURST    : cpu_HBURST;
  assign s_HMASTLOCK = grant_is_ldr ? ldr_HMASTLOCK : cpu_HMASTLOCK;
  assign s_HPROT     = grant_is_ldr ? ldr_HPROT     : cpu_HPROT;
  assign s_HSIZE     = grant_is_ldr ? ldr_HSIZE     : cpu_HSIZE;
  assign s_HTRANS    = grant_is_ldr ? ldr_HTRANS    : cpu_HTRANS;
  assign s_HWRITE    = grant_is_ldr ? ldr_HWRITE    : cpu_HWRITE;
  assign s_HWDATA    = dp_owner_q   ? ldr_HWDATA    : cpu_HWDATA;

  assign cpu_HRDATA     = s_HRDATA;
  assign cpu_HREADY     = (!grant_is_ldr || (dp_valid_q && !dp_owner_q)) ? s_HREADY : 1'b0;
  assign cpu_HRESP      = !dp_owner_q ? s_HRESP : 1'b0;
  assign grant_ldr      = grant_is_ldr;
  assign ldr_xfer_count = xfer_cnt_q;

  always_comb begin
    state_d        = state_q;
    dp_owner_d     = dp_owner_q;
    dp_valid_d     = dp_valid_q;
    slot_pending_d = slot_pending_q;
    ldr_active_d   = ldr_active_q;
    run_cnt_d      = run_cnt_q;
    xfer_cnt_d     = xfer_cnt_q;

    // Everything freezes across slave wait states.
    if (s_HREADY) begin
      dp_owner_d   = grant_is_ldr;
      dp_valid_d   = s_HTRANS[1];
      ldr_active_d = ldr_active;

      if (ldr_rise) begin
        xfer_cnt_d = '0;
      end else if (ldr_accept) begin
        xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      end

      if (!cpu_HTRANS[1]) begin
        run_cnt_d = '0;
      end else if (ldr_accept && (run_cnt_q != RUN_MAX_C)) begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
      end

      if (cpu_accept || !ldr_active) begin
        slot_pending_d = 1'b0;
      end

      if (state_q == CPU_OWN) begin
        if (ldr_active && handover_ok && !slot_pending_q) begin
          state_d = LDR_OWN;
        end
      end else begin
        if (handover_ok && (!ldr_active || force_cpu)) begin
          state_d        = CPU_OWN;
          run_cnt_d      = '0;
          // A forced slot returns to the loader once the CPU has had its transfer.
          slot_pending_d = ldr_active;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= CPU_OWN;
      dp_owner_q     <= 1'b0;
      dp_valid_q     <= 1'b0;
      slot_pending_q <= 1'b0;
      ldr_active_q   <= 1'b0;
      run_cnt_q      <= '0;
      xfer_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      dp_owner_q     <= dp_owner_d;
      dp_valid_q     <= dp_valid_d;
      slot_pending_q <= slot_pending_d;
      ldr_active_q   <= ldr_active_d;
      run_cnt_q      <= run_cnt_d;
      xfer_cnt_q     <= xfer_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mfp_ahb_master_arbiter : directed bench, strict-priority and LDR_RUN_MAX=4 copies
// Rev 1.0
// ============================================================================
module tb_mfp_ahb_master_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  always #5 HCLK = ~HCLK;

  logic [31:0] cpu_HADDR, cpu_HWDATA, ldr_HADDR, ldr_HWDATA, s_HRDATA;
  logic [2:0]  cpu_HBURST, cpu_HSIZE, ldr_HBURST, ldr_HSIZE;
  logic [3:0]  cpu_HPROT, ldr_HPROT;
  logic [1:0]  cpu_HTRANS, ldr_HTRANS;
  logic        cpu_HMASTLOCK, cpu_HWRITE, ldr_HMASTLOCK, ldr_HWRITE;
  logic        ldr_active, s_HREADY, s_HRESP;

  logic        d0_cpu_HREADY, d0_cpu_HRESP, d0_s_HMASTLOCK, d0_s_HWRITE, d0_grant_ldr;
  logic [31:0] d0_cpu_HRDATA, d0_s_HADDR, d0_s_HWDATA;
  logic [2:0]  d0_s_HBURST, d0_s_HSIZE;
  logic [3:0]  d0_s_HPROT;
  logic [1:0]  d0_s_HTRANS;
  logic [15:0] d0_cnt;

  logic        d4_cpu_HREADY, d4_cpu_HRESP, d4_s_HMASTLOCK, d4_s_HWRITE, d4_grant_ldr;
  logic [31:0] d4_cpu_HRDATA, d4_s_HADDR, d4_s_HWDATA;
  logic [2:0]  d4_s_HBURST, d4_s_HSIZE;
  logic [3:0]  d4_s_HPROT;
  logic [1:0]  d4_s_HTRANS;
  logic [15:0] d4_cnt;

  mfp_ahb_master_arbiter u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_HADDR(cpu_HADDR), .cpu_HWDATA(cpu_HWDATA), .cpu_HBURST(cpu_HBURST),
    .cpu_HMASTLOCK(cpu_HMASTLOCK), .cpu_HPROT(cpu_HPROT), .cpu_HSIZE(cpu_HSIZE),
    .cpu_HTRANS(cpu_HTRANS), .cpu_HWRITE(cpu_HWRITE),
    .cpu_HREADY(d0_cpu_HREADY), .cpu_HRESP(d0_cpu_HRESP), .cpu_HRDATA(d0_cpu_HRDATA),
    .ldr_HADDR(ldr_HADDR), .ldr_HWDATA(ldr_HWDATA), .ldr_HBURST(ldr_HBURST),
    .ldr_HMASTLOCK(ldr_HMASTLOCK), .ldr_HPROT(ldr_HPROT), .ldr_HSIZE(ldr_HSIZE),
    .ldr_HTRANS(ldr_HTRANS), .ldr_HWRITE(ldr_HWRITE), .ldr_active(ldr_active),
    .s_HADDR(d0_s_HADDR), .s_HWDATA(d0_s_HWDATA), .s_HBURST(d0_s_HBURST),
    .s_HMASTLOCK(d0_s_HMASTLOCK), .s_HPROT(d0_s_HPROT), .s_HSIZE(d0_s_HSIZE),
    .s_HTRANS(d0_s_HTRANS), .s_HWRITE(d0_s_HWRITE),
    .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA),
    .grant_ldr(d0_grant_ldr), .ldr_xfer_count(d0_cnt)
  );

  mfp_ahb_master_arbiter #(.LDR_RUN_MAX(4)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_HADDR(cpu_HADDR), .cpu_HWDATA(cpu_HWDATA), .cpu_HBURST(cpu_HBURST),
    .cpu_HMASTLOCK(cpu_HMASTLOCK), .cpu_HPROT(cpu_HPROT), .cpu_HSIZE(cpu_HSIZE),
    .cpu_HTRANS(cpu_HTRANS), .cpu_HWRITE(cpu_HWRITE),
    .cpu_HREADY(d4_cpu_HREADY), .cpu_HRESP(d4_cpu_HRESP), .cpu_HRDATA(d4_cpu_HRDATA),
    .ldr_HADDR(ldr_HADDR), .ldr_HWDATA(ldr_HWDATA), .ldr_HBURST(ldr_HBURST),
    .ldr_HMASTLOCK(ldr_HMASTLOCK), .ldr_HPROT(ldr_HPROT), .ldr_HSIZE(ldr_HSIZE),
    .ldr_HTRANS(ldr_HTRANS), .ldr_HWRITE(ldr_HWRITE), .ldr_active(ldr_active),
    .s_HADDR(d4_s_HADDR), .s_HWDATA(d4_s_HWDATA), .s_HBURST(d4_s_HBURST),
    .s_HMASTLOCK(d4_s_HMASTLOCK), .s_HPROT(d4_s_HPROT), .s_HSIZE(d4_s_HSIZE),
    .s_HTRANS(d4_s_HTRANS), .s_HWRITE(d4_s_HWRITE),
    .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA),
    .grant_ldr(d4_grant_ldr), .ldr_xfer_count(d4_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    cpu_HADDR = '0; cpu_HWDATA = '0; cpu_HBURST = '0; cpu_HMASTLOCK = 1'b0;
    cpu_HPROT = 4'h3; cpu_HSIZE = 3'd2; cpu_HTRANS = IDLE; cpu_HWRITE = 1'b0;
    ldr_HADDR = '0; ldr_HWDATA = '0; ldr_HBURST = '0; ldr_HMASTLOCK = 1'b0;
    ldr_HPROT = 4'h3; ldr_HSIZE = 3'd0; ldr_HTRANS = IDLE; ldr_HWRITE = 1'b1;
    ldr_active = 1'b0; s_HREADY = 1'b1; s_HRESP = 1'b0; s_HRDATA = '0;

    repeat (2) cyc();
    chk("rst_grant0", 32'(d0_grant_ldr), 32'd0);
    chk("rst_grant4", 32'(d4_grant_ldr), 32'd0);
    chk("rst_cnt0",   32'(d0_cnt), 32'd0);
    HRESETn = 1'b1;

    // CPU single write
    cpu_HTRANS = NONSEQ; cpu_HADDR = 32'hBF80_0000; cpu_HWRITE = 1'b1;
    #1;
    chk("t1_haddr",  d0_s_HADDR, 32'hBF80_0000);
    chk("t1_htrans", 32'(d0_s_HTRANS), 32'(NONSEQ));
    chk("t1_hready", 32'(d0_cpu_HREADY), 32'd1);
    cyc();
    cpu_HTRANS = IDLE; cpu_HWDATA = 32'h0000_1234; ldr_HWDATA = 32'hDEAD_BEEF;
    s_HRESP = 1'b1; s_HRDATA = 32'hCAFE_F00D;
    #1;
    chk("t1_hwdata", d0_s_HWDATA, 32'h0000_1234);
    chk("t1_hresp",  32'(d0_cpu_HRESP), 32'd1);
    chk("t1_hrdata", d0_cpu_HRDATA, 32'hCAFE_F00D);
    s_HREADY = 1'b0;
    #1;
    chk("t1_hready_wait", 32'(d0_cpu_HREADY), 32'd0);
    s_HREADY = 1'b1; s_HRESP = 1'b0;
    #1;
    chk("t1_hready_mirror", 32'(d0_cpu_HREADY), 32'd1);
    chk("t1_grant", 32'(d0_grant_ldr), 32'd0);
    cyc();

    // Loader takes over while CPU idle; CPU read stalls
    ldr_active = 1'b1;
    cyc();
    chk("t2_grant0", 32'(d0_grant_ldr), 32'd1);
    chk("t2_grant4", 32'(d4_grant_ldr), 32'd1);
    cpu_HTRANS = NONSEQ; cpu_HADDR = 32'h0000_1000; cpu_HWRITE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ldr_HTRANS = NONSEQ; ldr_HADDR = 32'h100 + 32'(i); ldr_HWDATA = 32'(i);
      #1;
      chk("t2_cpu_stall", 32'(d0_cpu_HREADY), 32'd0);
      if (i == 3) chk("t2_haddr_ldr", d0_s_HADDR, 32'h0000_0103);
      cyc();
    end
    ldr_HTRANS = IDLE; cpu_HTRANS = IDLE; ldr_HWDATA = 32'h77; s_HRESP = 1'b1;
    #1;
    chk("t2_cnt0", 32'(d0_cnt), 32'd8);
    chk("t2_cnt4", 32'(d4_cnt), 32'd8);
    chk("t2_hwdata_ldr", d0_s_HWDATA, 32'h77);
    chk("t2_hresp_blocked", 32'(d0_cpu_HRESP), 32'd0);
    s_HRESP = 1'b0;
    cyc();
    ldr_active = 1'b0;
    cyc();
    chk("t2_back_cpu0", 32'(d0_grant_ldr), 32'd0);
    chk("t2_back_cpu4", 32'(d4_grant_ldr), 32'd0);
    cyc();
    chk("t2_cnt_hold", 32'(d0_cnt), 32'd8);

    // ldr_active rises during an INCR4 burst with one wait state
    cpu_HBURST = 3'd3; cpu_HWRITE = 1'b1;
    cpu_HTRANS = NONSEQ; cpu_HADDR = 32'h2000;
    cyc();
    cpu_HTRANS = SEQ; cpu_HADDR = 32'h2004; cpu_HWDATA = 32'hA0; ldr_active = 1'b1;
    cyc();
    chk("t3_cnt_clear", 32'(d0_cnt), 32'd0);
    cpu_HADDR = 32'h2008; cpu_HWDATA = 32'hA1; s_HREADY = 1'b0;
    #1;
    chk("t3_wait_hready", 32'(d0_cpu_HREADY), 32'd0);
    cyc();
    chk("t3_wait_grant", 32'(d0_grant_ldr), 32'd0);
    s_HREADY = 1'b1;
    cyc();
    cpu_HADDR = 32'h200C; cpu_HWDATA = 32'hA2;
    cyc();
    chk("t3_grant_hold", 32'(d0_grant_ldr), 32'd0);
    cpu_HTRANS = IDLE; cpu_HWDATA = 32'hA3; ldr_HWDATA = 32'h55;
    #1;
    chk("t3_hwdata_last", d0_s_HWDATA, 32'hA3);
    chk("t3_grant_last", 32'(d0_grant_ldr), 32'd0);
    cyc();
    chk("t3_switch0", 32'(d0_grant_ldr), 32'd1);
    chk("t3_switch4", 32'(d4_grant_ldr), 32'd1);
    chk("t3_hwdata_after", d0_s_HWDATA, 32'hA3);
    cpu_HBURST = 3'd0;

    // Locked CPU sequence holds off the loader
    ldr_active = 1'b0;
    cyc();
    chk("t4_cpu_own", 32'(d0_grant_ldr), 32'd0);
    ldr_active = 1'b1; cpu_HMASTLOCK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_HTRANS = NONSEQ; cpu_HADDR = 32'h3000 + 32'(4 * i);
      cyc();
      chk("t4_locked0", 32'(d0_grant_ldr), 32'd0);
      chk("t4_locked4", 32'(d4_grant_ldr), 32'd0);
    end
    cpu_HTRANS = IDLE;
    cyc();
    chk("t4_lock_idle", 32'(d0_grant_ldr), 32'd0);
    cpu_HMASTLOCK = 1'b0;
    cyc();
    chk("t4_release0", 32'(d0_grant_ldr), 32'd1);
    chk("t4_release4", 32'(d4_grant_ldr), 32'd1);

    // Forced CPU slot every 4 loader transfers (u_dut4); strict priority on u_dut0
    cpu_HADDR = 32'h5000; cpu_HWRITE = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ldr_HTRANS = (k % 2 == 0) ? NONSEQ : IDLE;
      ldr_HADDR  = 32'h400 + 32'(k);
      cpu_HTRANS = (k == 9 || k == 19) ? IDLE : NONSEQ;
      #1;
      chk("t5_grant4", 32'(d4_grant_ldr), (k % 10 == 8 || k % 10 == 9) ? 32'd0 : 32'd1);
      chk("t5_hready4", 32'(d4_cpu_HREADY), (k % 10 == 8 || k % 10 == 9) ? 32'd1 : 32'd0);
      chk("t5_grant0", 32'(d0_grant_ldr), 32'd1);
      cyc();
    end
    ldr_HTRANS = IDLE; cpu_HTRANS = IDLE;
    #1;
    chk("t5_cnt4", 32'(d4_cnt), 32'd8);
    chk("t5_cnt0", 32'(d0_cnt), 32'd10);
    cyc();

    // Counter wrap: u_dut0 sits at 10, u_dut4 at 8
    ldr_HTRANS = NONSEQ;
    repeat (65525) cyc();
    chk("t6_cnt_max0", 32'(d0_cnt), 32'h0000_FFFF);
    chk("t6_cnt_max4", 32'(d4_cnt), 32'h0000_FFFD);
    cyc();
    chk("t6_cnt_wrap0", 32'(d0_cnt), 32'h0000_0000);
    chk("t6_cnt_wrap4", 32'(d4_cnt), 32'h0000_FFFE);

    // Asynchronous reset in the middle of a loader transfer
    chk("t7_pre_grant", 32'(d0_grant_ldr), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t7_grant0", 32'(d0_grant_ldr), 32'd0);
    chk("t7_grant4", 32'(d4_grant_ldr), 32'd0);
    chk("t7_cnt0",   32'(d0_cnt), 32'd0);
    chk("t7_cnt4",   32'(d4_cnt), 32'd0);
    chk("t7_haddr",  d0_s_HADDR, 32'h5000);
    #3;
    HRESETn = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
